restador_serie_8bits: RTL and testbench
=======================================

# restador_serie_8bits

Bit-serial unsigned subtractor that computes A − B one bit per clock, LSB first, behind a start/ready/valid handshake. It is the subtraction counterpart of the combinational 8-bit adder: it trades the ripple-borrow chain for a single full-subtractor cell plus registers. It sits beside the adder in the arithmetic datapath wherever area matters more than latency.

## Interface
- N, 8, operand and result width in bits (N ≥ 2)
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- inicio  input  1  start request; accepted only when listo=1
- A  input  N  minuend, unsigned; sampled on the accept edge
- B  input  N  subtrahend, unsigned; sampled on the accept edge
- listo  output  1  ready; high in states REPOSO and FIN
- valido  output  1  one-cycle pulse; Resta/Prestamo are new this cycle
- Resta  output  N  (A − B) mod 2^N
- Prestamo  output  1  final borrow out; 1 iff A < B

## Operation
- Reset: one clock is synchronous and active-low. On any edge with rst_n=0: state→REPOSO, bit counter→0, internal borrow→0, Resta→0, Prestamo→0, valido→0. listo=1 after that edge.
- States:
  - REPOSO: idle. If inicio=1 → CALCULO, latch A and B into shift registers, clear the borrow, counter→0.
  - CALCULO: each edge processes bit i = counter:
    - d = a_i ^ b_i ^ bin
    - bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin)
    - d shifts into the result shift register from the MSB side, and bout becomes the new bin.
    - When counter = N−1, go to FIN, and on that same edge copy the complete result into Resta and bout into Prestamo.
  - FIN: valido=1 for this one cycle. If inicio=1 → CALCULO with new operands (back-to-back). Otherwise → REPOSO.
- inicio while listo=0 is ignored. A and B changes while busy have no effect.
- Resta and Prestamo change only on the completion edge or on reset. They never show partial results, and they hold until the next completion.
- Arithmetic: Prestamo:Resta equals the N+1-bit two's-complement of A − B. Examples:
  - 0 − 1 → Resta = 2^N − 1, Prestamo = 1
  - x − x → Resta = 0, Prestamo = 0

## Timing
- Accept edge E0 is the edge where inicio=1 and listo=1.
- CALCULO spans edges E1..EN. The result registers update at edge EN, and valido=1 in the cycle after EN.
- Latency: N clocks from accept edge to valid result. For N=8, valido is high in the cycle after E8.
- Throughput with inicio held high: one result every N+1 clocks, because the next operation is accepted at the FIN edge (E(N+1)).
- listo is 0 from after E0 through EN. It returns to 1 for the FIN cycle.
- Reset mid-operation aborts the operation with no valido pulse, and all outputs take their reset values.
- inicio=1 together with rst_n=0: reset wins and the start is dropped.

## Structure
- Package restador_pkg holds:
  - the state typedef estado_t {REPOSO, CALCULO, FIN}
  - the default width constant ANCHO_DEF = 8
  - the counter width $clog2(N)
- Sub-module restador_completo is a combinational 1-bit full subtractor (a, b, bin → d, bout). It is instantiated once and shared by the serial datapath.
- Top level holds the FSM, the counter, the operand and result shift registers, the borrow flop, and the output registers.

## Test plan
- Reset, then A=5, B=3, pulse inicio → listo drops after the accept edge; valido pulses 8 clocks later; Resta=2, Prestamo=0; outputs hold afterwards.
- A=3, B=5 → Resta=254, Prestamo=1. Also A=0, B=1 → Resta=255, Prestamo=1.
- A=100, B=73 → Resta=27, Prestamo=0. Also A=255, B=255 → Resta=0, Prestamo=0.
- Hold inicio=1 with A=100, B=15 then A=12, B=30 → first result Resta=85, Prestamo=0; second accepted in FIN and returns Resta=238, Prestamo=1 exactly 9 clocks after the first valido.
- Toggle inicio and change A/B while listo=0 → no extra accept; result matches the operands latched at accept.
- rst_n=0 at edge E4 of an operation → no valido; Resta=0, Prestamo=0, listo=1. Then a new 10−10 completes normally with Resta=0, Prestamo=0.

Source files
------------

// File: rtl/restador_pkg.sv
// rtl/restador_pkg.sv - shared types and constants for the bit-serial subtractor
package restador_pkg;

  typedef enum logic [1:0] {REPOSO, CALCULO, FIN} estado_t;

  localparam int ANCHO_DEF = 8;

  // Bit-counter width for an n-bit operand; never narrower than one bit.
  function automatic int ancho_cont(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/restador_completo.sv
// rtl/restador_completo.sv - combinational 1-bit full subtractor cell
module restador_completo (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/restador_serie_8bits.sv
// rtl/restador_serie_8bits.sv - LSB-first serial A-B with start/ready/valid handshake
module restador_serie_8bits
  import restador_pkg::*;
#(
  parameter int N = ANCHO_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inicio,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         listo,
  output logic         valido,
  output logic [N-1:0] Resta,
  output logic         Prestamo
);

  localparam int            CW     = ancho_cont(N);
  localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

  estado_t       estado, estado_sig;
  logic [CW-1:0] cont;
  logic [N-1:0]  a_sr, b_sr, res_sr;
  logic          bin, d, bout;
  logic          ultimo, acepta;

  restador_completo u_celda (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (bin),
    .d   (d),
    .bout(bout)
  );

  assign ultimo = (cont == ULTIMO);
  assign listo  = (estado != CALCULO);
  assign valido = (estado == FIN);
  assign acepta = listo && inicio;

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:  if (inicio) estado_sig = CALCULO;
      CALCULO: if (ultimo) estado_sig = FIN;
      FIN:     estado_sig = inicio ? CALCULO : REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado   <= REPOSO;
      cont     <= '0;
      bin      <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      Resta    <= '0;
      Prestamo <= 1'b0;
    end else begin
      estado <= estado_sig;
      if (acepta) begin
        a_sr <= A;
        b_sr <= B;
        bin  <= 1'b0;
        cont <= '0;
      end else if (estado == CALCULO) begin
        // Difference bits enter at the MSB so bit 0 lands at the LSB after N shifts.
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        res_sr <= {d, res_sr[N-1:1]};
        bin    <= bout;
        cont   <= cont + CW'(1);
        if (ultimo) begin
          Resta    <= {d, res_sr[N-1:1]};
          Prestamo <= bout;
        end
      end
    end
  end

endmodule

// File: tb/tb_restador_serie_8bits.sv
// tb/tb_restador_serie_8bits.sv - directed scoreboard bench for restador_serie_8bits
module tb_restador_serie_8bits;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inicio;
  logic [7:0] A, B;
  logic       listo, valido, Prestamo;
  logic [7:0] Resta;

  typedef struct packed {
    logic [7:0] r;
    logic       p;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  restador_serie_8bits dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inicio  (inicio),
    .A       (A),
    .B       (B),
    .listo   (listo),
    .valido  (valido),
    .Resta   (Resta),
    .Prestamo(Prestamo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t modelo(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] full;
    exp_t e;
    full = {1'b0, a} - {1'b0, b};
    e.r  = full[7:0];
    e.p  = full[8];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands with inicio for one accept edge, then releases inicio.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    A      = a;
    B      = b;
    inicio = 1'b1;
    sb.push_back(modelo(a, b));
    tick();
    inicio = 1'b0;
  endtask

  // Waits for valido within a cycle budget; returns cycles waited.
  task automatic wait_valido(input string tag, output int ciclos);
    ciclos = 0;
    while (!valido && ciclos < 40) begin
      tick();
      ciclos++;
    end
    if (!valido) check({tag, "_timeout"}, 32'(valido), 32'd1);
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_resta"}, 32'(Resta), 32'(e.r));
      check({tag, "_prestamo"}, 32'(Prestamo), 32'(e.p));
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b);
    int c;
    start_op(a, b);
    wait_valido(tag, c);
    if (valido) compare_result(tag);
    tick();
  endtask

  initial begin
    int   c;
    int   pulsos;
    exp_t e;

    rst_n  = 1'b0;
    inicio = 1'b0;
    A      = '0;
    B      = '0;
    tick();
    tick();
    check("rst_listo", 32'(listo), 32'd1);
    check("rst_valido", 32'(valido), 32'd0);
    check("rst_resta", 32'(Resta), 32'd0);
    check("rst_prestamo", 32'(Prestamo), 32'd0);
    rst_n = 1'b1;
    tick();

    // 5-3: latency, listo drop, hold afterwards
    start_op(8'd5, 8'd3);
    check("busy_listo", 32'(listo), 32'd0);
    wait_valido("op5_3", c);
    check("latency", 32'(c), 32'd8);
    check("fin_listo", 32'(listo), 32'd1);
    compare_result("op5_3");
    tick();
    check("hold_valido", 32'(valido), 32'd0);
    repeat (3) tick();
    check("hold_resta", 32'(Resta), 32'd2);
    check("hold_prestamo", 32'(Prestamo), 32'd0);

    run_op("op3_5", 8'd3, 8'd5);
    run_op("op0_1", 8'd0, 8'd1);
    run_op("op100_73", 8'd100, 8'd73);
    run_op("op255_255", 8'd255, 8'd255);

    // Back-to-back with inicio held high
    A      = 8'd100;
    B      = 8'd15;
    inicio = 1'b1;
    sb.push_back(modelo(8'd100, 8'd15));
    tick();
    A = 8'd12;
    B = 8'd30;
    wait_valido("b2b_first", c);
    if (valido) begin
      compare_result("b2b_first");
      sb.push_back(modelo(8'd12, 8'd30));
      tick();
      inicio = 1'b0;
      c = 1;
      while (!valido && c < 40) begin
        tick();
        c++;
      end
      check("b2b_spacing", 32'(c), 32'd9);
      if (valido) compare_result("b2b_second");
    end
    inicio = 1'b0;
    tick();

    // Inicio toggles and operand changes while busy are ignored
    start_op(8'd50, 8'd20);
    for (int i = 0; i < 4; i++) begin
      inicio = ~inicio;
      A      = 8'($urandom);
      B      = 8'($urandom);
      tick();
    end
    inicio = 1'b0;
    wait_valido("busy_ign", c);
    if (valido) compare_result("busy_ign");
    pulsos = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valido) pulsos++;
    end
    check("no_extra_accept", 32'(pulsos), 32'd0);

    // Reset at E4 aborts the operation
    start_op(8'd200, 8'd7);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    check("abort_listo", 32'(listo), 32'd1);
    check("abort_valido", 32'(valido), 32'd0);
    check("abort_resta", 32'(Resta), 32'd0);
    check("abort_prestamo", 32'(Prestamo), 32'd0);
    pulsos = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valido) pulsos++;
    end
    check("abort_no_valido", 32'(pulsos), 32'd0);

    run_op("op10_10", 8'd10, 8'd10);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
